// File: rtl/viterbi_pkg.sv
// Shared constants, types and trellis helpers for the K=3, rate-1/2 (7,5) Viterbi decoder.
package viterbi_pkg;
  localparam int K          = 3;
  localparam int NUM_STATES = 4;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  typedef logic [1:0] state_t;

  function automatic state_t next_state(input state_t p, input logic u);
    return {u, p[1]};
  endfunction

  // Generator taps apply to {u, p1, p0}
  function automatic logic [1:0] exp_word(input state_t p, input logic u);
    logic [2:0] r;
    r = {u, p};
    return {^(r & G0), ^(r & G1)};
  endfunction
endpackage

// File: rtl/hamming_distance.sv
// 2-bit Hamming distance between a received symbol and a candidate code word.
module hamming_distance (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [1:0] o_dist
);
  logic [1:0] w_x;
  assign w_x    = i_a ^ i_b;
  assign o_dist = {1'b0, w_x[1]} + {1'b0, w_x[0]};
endmodule

// File: rtl/viterbi_acs.sv
// Add-compare-select for one next state; ties resolve to the p0=0 predecessor.
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [1:0]      i_bm0,
  input  logic [1:0]      i_bm1,
  output logic            o_sel,
  output logic [PM_W+1:0] o_sum
);
  logic [PM_W+1:0] w_c0, w_c1;
  assign w_c0  = {2'b00, i_pm0} + {{PM_W{1'b0}}, i_bm0};
  assign w_c1  = {2'b00, i_pm1} + {{PM_W{1'b0}}, i_bm1};
  assign o_sel = (w_c1 < w_c0);
  assign o_sum = o_sel ? w_c1 : w_c0;
endmodule

// File: rtl/viterbi_pmu.sv
// Path metric unit: branch metrics, 4x ACS, normalisation and a one-deep output register
// with valid/ready flow control toward traceback.
module viterbi_pmu
  import viterbi_pkg::*;
#(
  parameter int PM_W    = 6,
  parameter int INIT_PM = 31
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_valid,
  input  logic [1:0]             i_data,
  output logic                   o_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [3:0]             o_decision,
  output logic [1:0]             o_best_state,
  output logic [4*PM_W-1:0]      o_pm
);
  localparam int SW = PM_W + 2;
  localparam logic [SW-1:0] PM_MAX = {2'b00, {PM_W{1'b1}}};
  localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_INIT =
    {PM_W'(INIT_PM), PM_W'(INIT_PM), PM_W'(INIT_PM), PM_W'(0)};

  logic [NUM_STATES-1:0][PM_W-1:0] r_pm, r_opm, w_old, w_norm;
  logic [NUM_STATES-1:0][SW-1:0]   w_sum, w_sub;
  logic [NUM_STATES-1:0][1:0]      w_bm;
  logic [NUM_STATES-1:0]           w_dec;
  logic [SW-1:0]                   w_min;
  state_t                          w_best;
  logic                            w_ready, w_acc;
  logic                            r_valid;
  logic [NUM_STATES-1:0]           r_dec;
  state_t                          r_best;

  assign w_ready = i_ready || !r_valid;
  assign w_acc   = i_valid && w_ready;
  // A start beat decodes from the frame-start metrics rather than the registers
  assign w_old   = i_start ? PM_INIT : r_pm;

  genvar g;
  generate
    for (g = 0; g < NUM_STATES; g++) begin : g_bm
      hamming_distance u_hd (
        .i_a    (i_data),
        .i_b    (2'(g)),
        .o_dist (w_bm[g])
      );
    end

    for (g = 0; g < NUM_STATES; g++) begin : g_acs
      localparam state_t     NS = state_t'(g);
      localparam state_t     PA = {NS[0], 1'b0};
      localparam state_t     PB = {NS[0], 1'b1};
      localparam logic [1:0] EA = exp_word(PA, NS[1]);
      localparam logic [1:0] EB = exp_word(PB, NS[1]);
      viterbi_acs #(.PM_W(PM_W)) u_acs (
        .i_pm0 (w_old[PA]),
        .i_pm1 (w_old[PB]),
        .i_bm0 (w_bm[EA]),
        .i_bm1 (w_bm[EB]),
        .o_sel (w_dec[g]),
        .o_sum (w_sum[g])
      );
    end
  endgenerate

  // Strict compare keeps the lowest index among equal minima
  always_comb begin
    w_min  = w_sum[0];
    w_best = '0;
    for (int i = 1; i < NUM_STATES; i++) begin
      if (w_sum[i] < w_min) begin
        w_min  = w_sum[i];
        w_best = state_t'(i);
      end
    end
    for (int i = 0; i < NUM_STATES; i++) begin
      w_sub[i]  = w_sum[i] - w_min;
      w_norm[i] = (w_sub[i] > PM_MAX) ? {PM_W{1'b1}} : w_sub[i][PM_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_dec   <= '0;
      r_best  <= '0;
      r_opm   <= '0;
      r_pm    <= PM_INIT;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_dec   <= w_dec;
      r_best  <= w_best;
      r_opm   <= w_norm;
      r_pm    <= w_norm;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready      = w_ready;
  assign o_valid      = r_valid;
  assign o_decision   = r_dec;
  assign o_best_state = r_best;
  assign o_pm         = r_opm;
endmodule

// File: tb/tb_viterbi_pmu.sv
// Randomised and directed checks of viterbi_pmu against a trellis-level reference model.
module tb_viterbi_pmu;
  localparam int PM_W = 6;
  localparam int INIT = 31;
  localparam int MAXV = 63;

  logic        clk = 1'b0;
  logic        rst, start, valid, rdy;
  logic [1:0]  data;
  logic        o_ready, o_valid;
  logic [3:0]  o_dec;
  logic [1:0]  o_best;
  logic [23:0] o_pm;

  int total = 0, bad = 0;
  int mpm[4], opm[4];
  int mdec, mbest;
  bit mval;

  viterbi_pmu #(.PM_W(PM_W), .INIT_PM(INIT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid), .i_data(data),
    .o_ready(o_ready), .o_valid(o_valid), .i_ready(rdy),
    .o_decision(o_dec), .o_best_state(o_best), .o_pm(o_pm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mpm[0] = 0;
    for (int n = 1; n < 4; n++) mpm[n] = INIT;
    for (int n = 0; n < 4; n++) opm[n] = 0;
    mdec = 0; mbest = 0; mval = 0;
  endtask

  // Trellis step from first principles: predecessor p=(p1,p0), input u, word {u^p1^p0, u^p0}
  task automatic model_beat(input bit st, input logic [1:0] d);
    int old[4], nw[4];
    int mn, u, p1, p, c0, c1, bm, c, bestc;
    for (int n = 0; n < 4; n++) old[n] = st ? ((n == 0) ? 0 : INIT) : mpm[n];
    mdec = 0;
    for (int n = 0; n < 4; n++) begin
      u = n / 2; p1 = n % 2; bestc = 0;
      for (int p0 = 0; p0 < 2; p0++) begin
        p  = 2 * p1 + p0;
        c0 = u ^ p1 ^ p0;
        c1 = u ^ p0;
        bm = ((int'(d[1]) != c0) ? 1 : 0) + ((int'(d[0]) != c1) ? 1 : 0);
        c  = old[p] + bm;
        if (p0 == 0) bestc = c;
        else if (c < bestc) begin bestc = c; mdec = mdec | (1 << n); end
      end
      nw[n] = bestc;
    end
    mn = nw[0];
    for (int n = 1; n < 4; n++) if (nw[n] < mn) mn = nw[n];
    mbest = 0;
    for (int n = 3; n >= 0; n--) if (nw[n] == mn) mbest = n;
    for (int n = 0; n < 4; n++) begin
      opm[n] = (nw[n] - mn > MAXV) ? MAXV : nw[n] - mn;
      mpm[n] = opm[n];
    end
    mval = 1;
  endtask

  function automatic logic [23:0] pack_pm();
    logic [23:0] r;
    for (int n = 0; n < 4; n++) r[n*6 +: 6] = 6'(opm[n]);
    return r;
  endfunction

  // One clock: drive just after a falling edge, check registered outputs at the next one
  task automatic cyc(input bit r, input bit v, input bit st, input logic [1:0] d, input bit rd);
    bit er;
    logic [23:0] fld;
    rst = r; valid = v; start = st; data = d; rdy = rd;
    #1;
    er = rd || !mval;
    chk("o_ready", {31'd0, o_ready}, {31'd0, er});
    if (r) model_reset();
    else if (v && er) model_beat(st, d);
    else if (rd) mval = 0;
    @(negedge clk);
    chk("o_valid", {31'd0, o_valid}, {31'd0, mval});
    chk("o_dec", {28'd0, o_dec}, 32'(mdec));
    chk("o_best", {30'd0, o_best}, 32'(mbest));
    chk("o_pm", {8'd0, o_pm}, {8'd0, pack_pm()});
    if (o_valid) begin
      fld = o_pm >> (o_best * 6);
      chk("best_pm_zero", {26'd0, fld[5:0]}, 32'd0);
    end
  endtask

  logic [1:0] sym[4];

  initial begin
    sym[0] = 2'b11; sym[1] = 2'b10; sym[2] = 2'b00; sym[3] = 2'b01;
    rst = 1; valid = 0; start = 0; data = 0; rdy = 1;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_pm", {8'd0, o_pm}, 32'd0);
    chk("rst_dec", {28'd0, o_dec}, 32'd0);
    chk("rst_best", {30'd0, o_best}, 32'd0);

    // Start with symbol 00: s1/s3 see tied candidates
    cyc(0, 1, 1, 2'b00, 1);
    chk("t1_pm", {8'd0, o_pm}, {8'd0, 6'd32, 6'd2, 6'd32, 6'd0});
    chk("t1_dec", {28'd0, o_dec}, 32'd0);
    chk("t1_best", {30'd0, o_best}, 32'd0);
    cyc(0, 1, 0, 2'b11, 1);
    // Mid-frame start re-initialises the metrics
    cyc(0, 1, 1, 2'b00, 1);
    chk("restart_pm", {8'd0, o_pm}, {8'd0, 6'd32, 6'd2, 6'd32, 6'd0});
    cyc(0, 0, 0, 2'b00, 1);

    // Noiseless frame for bits 1,0,1,1
    cyc(0, 1, 1, sym[0], 1); chk("ns_best0", {30'd0, o_best}, 32'd2);
    cyc(0, 1, 0, sym[1], 1); chk("ns_best1", {30'd0, o_best}, 32'd1);
    cyc(0, 1, 0, sym[2], 1); chk("ns_best2", {30'd0, o_best}, 32'd2);
    cyc(0, 1, 0, sym[3], 1); chk("ns_best3", {30'd0, o_best}, 32'd3);
    cyc(0, 0, 0, 2'b00, 1);  chk("ns_idle", {31'd0, o_valid}, 32'd0);

    // Same frame with a 3-cycle traceback stall after the first output
    cyc(0, 1, 1, sym[0], 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, sym[1], 0);
      chk("stall_ready", {31'd0, o_ready}, 32'd0);
      chk("stall_best", {30'd0, o_best}, 32'd2);
    end
    cyc(0, 1, 0, sym[1], 1); chk("st_best1", {30'd0, o_best}, 32'd1);
    cyc(0, 1, 0, sym[2], 1); chk("st_best2", {30'd0, o_best}, 32'd2);
    cyc(0, 1, 0, sym[3], 1); chk("st_best3", {30'd0, o_best}, 32'd3);
    cyc(0, 0, 0, 2'b00, 1);

    // Reset during the third beat of a frame, then a fresh frame
    cyc(0, 1, 1, 2'b01, 1);
    cyc(0, 1, 0, 2'b10, 1);
    cyc(1, 1, 0, 2'b11, 1);
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_pm", {8'd0, o_pm}, 32'd0);
    cyc(0, 1, 1, 2'b00, 1);
    chk("post_rst_pm", {8'd0, o_pm}, {8'd0, 6'd32, 6'd2, 6'd32, 6'd0});

    // Randomised traffic with random stalls and occasional restarts
    for (int k = 0; k < 200; k++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0));
    end
    cyc(0, 0, 0, 2'b00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
